// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state encoding and owner constants for the memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Requester handshakes plus the shared memory port of the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic              m0_req;
    logic              m1_req;
    logic              m0_write;
    logic              m1_write;
    logic [ADDR_W-1:0] m0_addr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m1_wdata;
    logic              m0_gnt;
    logic              m1_gnt;
    logic              m0_rvalid;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] to_memory;
    logic              write;
    logic [DATA_W-1:0] from_memory;
    logic              busy;

    // Requesters and the memory together form the environment around the arbiter.
    modport master (
        output m0_req, m1_req, m0_write, m1_write, m0_addr, m1_addr,
        output m0_wdata, m1_wdata, from_memory,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  address, to_memory, write, busy
    );

    modport slave (
        input  m0_req, m1_req, m0_write, m1_write, m0_addr, m1_addr,
        input  m0_wdata, m1_wdata, from_memory,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output address, to_memory, write, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational two-way winner selection, round-robin or fixed.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       fixed_prio,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = OWN_M0;
        case (req)
            2'b01:   winner = OWN_M0;
            2'b10:   winner = OWN_M1;
            // On a tie the previous owner yields unless requester 0 is pinned.
            2'b11:   winner = fixed_prio ? OWN_M0 : ~last_owner;
            default: winner = OWN_M0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one synchronous memory port between two one-beat masters.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic c_fixed_prio = (FIXED_PRIO != 0);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_owner;
    logic              r_last_owner;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_to_memory;
    logic              r_write;
    logic              w_valid;
    logic              w_winner;
    logic              w_load;
    logic              w_access;
    logic              w_resp;

    rr_pick u_pick (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_owner (r_last_owner),
        .fixed_prio (c_fixed_prio),
        .valid      (w_valid),
        .winner     (w_winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_valid) begin
                    w_state_next = ARB_ACCESS;
                    w_load       = 1'b1;
                end
            end
            // A write needs no response beat, so it returns straight to IDLE.
            ARB_ACCESS: w_state_next = r_write ? ARB_IDLE : ARB_RESP;
            ARB_RESP:   w_state_next = ARB_IDLE;
            default:    w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= OWN_M0;
            r_last_owner <= OWN_M1;
            r_address    <= '0;
            r_to_memory  <= '0;
            r_write      <= 1'b0;
        end else if (w_load) begin
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_address    <= (w_winner == OWN_M1) ? bus.m1_addr  : bus.m0_addr;
            r_to_memory  <= (w_winner == OWN_M1) ? bus.m1_wdata : bus.m0_wdata;
            r_write      <= (w_winner == OWN_M1) ? bus.m1_write : bus.m0_write;
        end else if (r_state == ARB_ACCESS) begin
            // Address and data are left in place; only the strobe is retired.
            r_write      <= 1'b0;
        end
    end

    assign w_access = (r_state == ARB_ACCESS);
    assign w_resp   = (r_state == ARB_RESP);

    assign bus.m0_gnt    = w_access && (r_owner == OWN_M0);
    assign bus.m1_gnt    = w_access && (r_owner == OWN_M1);
    assign bus.m0_rvalid = w_resp   && (r_owner == OWN_M0);
    assign bus.m1_rvalid = w_resp   && (r_owner == OWN_M1);
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.from_memory : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.from_memory : '0;

    assign bus.address   = r_address;
    assign bus.to_memory = r_to_memory;
    assign bus.write     = r_write;
    assign bus.busy      = (r_state != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Round-robin and fixed-priority arbiters against an event model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_m0_req, s_m1_req, s_m0_write, s_m1_write;
    logic [7:0] s_m0_addr, s_m1_addr, s_m0_wdata, s_m1_wdata;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_dut_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    assign bus0.m0_req   = s_m0_req;    assign bus1.m0_req   = s_m0_req;
    assign bus0.m1_req   = s_m1_req;    assign bus1.m1_req   = s_m1_req;
    assign bus0.m0_write = s_m0_write;  assign bus1.m0_write = s_m0_write;
    assign bus0.m1_write = s_m1_write;  assign bus1.m1_write = s_m1_write;
    assign bus0.m0_addr  = s_m0_addr;   assign bus1.m0_addr  = s_m0_addr;
    assign bus0.m1_addr  = s_m1_addr;   assign bus1.m1_addr  = s_m1_addr;
    assign bus0.m0_wdata = s_m0_wdata;  assign bus1.m0_wdata = s_m0_wdata;
    assign bus0.m1_wdata = s_m1_wdata;  assign bus1.m1_wdata = s_m1_wdata;

    function automatic logic [7:0] init_val(input int a);
        return (a == 32) ? 8'h3C : 8'(a * 7 + 3);
    endfunction

    // Synchronous memories, one per arbiter: read data appears the cycle after the address.
    logic [7:0] mem [2][256];
    logic [7:0] from_mem [2];
    logic       mem_loaded = 1'b0;
    assign bus0.from_memory = from_mem[0];
    assign bus1.from_memory = from_mem[1];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem[0][i] <= init_val(i);
                mem[1][i] <= init_val(i);
            end
            mem_loaded <= 1'b1;
        end else begin
            if (bus0.write) mem[0][bus0.address] <= bus0.to_memory;
            if (bus1.write) mem[1][bus1.address] <= bus1.to_memory;
        end
        from_mem[0] <= mem[0][bus0.address];
        from_mem[1] <= mem[1][bus1.address];
    end

    // Event-schedule model: a grant at edge e books gnt at e, rvalid at e+1, next sample at e+2/e+3.
    int         cyc;
    int         m_free    [2];
    int         m_gnt_cyc [2];
    int         m_rv_cyc  [2];
    int         m_wr_cyc  [2];
    logic       m_gnt_who [2];
    logic       m_rv_who  [2];
    logic       m_last    [2];
    logic [7:0] m_rv_data [2];
    logic [7:0] m_addr    [2];
    logic [7:0] m_wdata   [2];
    logic [7:0] ref_mem   [2][256];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_free[d] = 0;     m_gnt_cyc[d] = -1; m_rv_cyc[d] = -1; m_wr_cyc[d] = -1;
            m_gnt_who[d] = 0;  m_rv_who[d] = 0;   m_last[d] = 1'b1;
            m_rv_data[d] = 0;  m_addr[d] = 0;     m_wdata[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        logic       who, wr;
        logic [7:0] a, wd;
        if (cyc >= m_free[d] && (s_m0_req || s_m1_req)) begin
            if (s_m0_req && s_m1_req) who = (d == 1) ? 1'b0 : !m_last[d];
            else                      who = s_m1_req;
            wr = who ? s_m1_write : s_m0_write;
            a  = who ? s_m1_addr  : s_m0_addr;
            wd = who ? s_m1_wdata : s_m0_wdata;
            m_last[d] = who;  m_addr[d] = a;  m_wdata[d] = wd;
            m_gnt_cyc[d] = cyc;  m_gnt_who[d] = who;
            if (wr) begin
                ref_mem[d][a] = wd;
                m_wr_cyc[d] = cyc;
                m_free[d] = cyc + 2;
            end else begin
                m_rv_cyc[d] = cyc + 1;
                m_rv_who[d] = who;
                m_rv_data[d] = ref_mem[d][a];
                m_free[d] = cyc + 3;
            end
        end
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = init_val(i);
            ref_mem[1][i] = init_val(i);
        end
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else begin
                cyc = cyc + 1;
                model_step(0);
                model_step(1);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic       log_en = 1'b0;
    int         g_who [$];
    int         g_cyc [$];
    int         fp_m0 = 0;
    int         fp_m1 = 0;
    logic [37:0] act_v [2];
    logic [37:0] exp_v;

    initial begin
        forever begin
            @(negedge clk);
            act_v[0] = {bus0.m0_gnt, bus0.m1_gnt, bus0.m0_rvalid, bus0.m1_rvalid, bus0.m0_rdata,
                        bus0.m1_rdata, bus0.address, bus0.to_memory, bus0.write, bus0.busy};
            act_v[1] = {bus1.m0_gnt, bus1.m1_gnt, bus1.m0_rvalid, bus1.m1_rvalid, bus1.m0_rdata,
                        bus1.m1_rdata, bus1.address, bus1.to_memory, bus1.write, bus1.busy};
            for (int d = 0; d < 2; d++) begin
                logic g, v;
                g = (m_gnt_cyc[d] == cyc);
                v = (m_rv_cyc[d] == cyc);
                exp_v = {g && !m_gnt_who[d], g && m_gnt_who[d], v && !m_rv_who[d], v && m_rv_who[d],
                         (v && !m_rv_who[d]) ? m_rv_data[d] : 8'h00,
                         (v && m_rv_who[d])  ? m_rv_data[d] : 8'h00,
                         m_addr[d], m_wdata[d], (m_wr_cyc[d] == cyc),
                         (m_gnt_cyc[d] >= 0) && (cyc < m_free[d] - 1)};
                checks++;
                if (act_v[d] !== exp_v) begin
                    errors++;
                    $display("FAIL cycle_compare dut%0d cyc %0d: got %h expected %h", d, cyc, act_v[d], exp_v);
                end
            end
            if (log_en) begin
                if (bus0.m0_gnt) begin g_who.push_back(0); g_cyc.push_back(cyc); end
                if (bus0.m1_gnt) begin g_who.push_back(1); g_cyc.push_back(cyc); end
                if (bus1.m0_gnt) fp_m0++;
                if (bus1.m1_gnt) fp_m1++;
            end
        end
    end

    initial begin
        reset = 1'b0;
        s_m0_req = 0; s_m1_req = 0; s_m0_write = 0; s_m1_write = 0;
        s_m0_addr = 0; s_m1_addr = 0; s_m0_wdata = 0; s_m1_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_address", 32'(bus0.address), 'h0);
        check("rst_to_memory", 32'(bus0.to_memory), 'h0);
        check("rst_write", 32'(bus0.write), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_handshake", 32'({bus0.m0_gnt, bus0.m1_gnt, bus0.m0_rvalid, bus0.m1_rvalid}), 0);
        repeat (3) @(negedge clk);
        check("idle_address", 32'(bus0.address), 'h0);
        check("idle_write", 32'(bus0.write), 0);

        // m0 write 0x10 <= 0xA5
        @(posedge clk); #1;
        s_m0_req = 1; s_m0_write = 1; s_m0_addr = 8'h10; s_m0_wdata = 8'hA5;
        @(posedge clk); @(negedge clk);
        check("wr_m0_gnt", 32'(bus0.m0_gnt), 1);
        check("wr_m1_gnt", 32'(bus0.m1_gnt), 0);
        check("wr_address", 32'(bus0.address), 'h10);
        check("wr_to_memory", 32'(bus0.to_memory), 'hA5);
        check("wr_strobe", 32'(bus0.write), 1);
        @(posedge clk); #1 s_m0_req = 0; s_m0_write = 0;
        @(negedge clk);
        check("wr_done_write", 32'(bus0.write), 0);
        check("wr_done_busy", 32'(bus0.busy), 0);
        check("wr_no_rvalid", 32'(bus0.m0_rvalid), 0);
        check("wr_addr_hold", 32'(bus0.address), 'h10);

        // m1 read 0x20 -> 0x3C
        @(posedge clk); #1;
        s_m1_req = 1; s_m1_write = 0; s_m1_addr = 8'h20;
        @(posedge clk); @(negedge clk);
        check("rd_m1_gnt", 32'(bus0.m1_gnt), 1);
        check("rd_m0_rdata_gnt", 32'(bus0.m0_rdata), 0);
        @(posedge clk); #1 s_m1_req = 0;
        @(negedge clk);
        check("rd_m1_rvalid", 32'(bus0.m1_rvalid), 1);
        check("rd_m1_rdata", 32'(bus0.m1_rdata), 'h3C);
        check("rd_m0_rdata", 32'(bus0.m0_rdata), 0);
        @(negedge clk);
        check("rd_done_busy", 32'(bus0.busy), 0);
        check("rd_done_rdata", 32'(bus0.m1_rdata), 0);

        // both hold read requests
        @(posedge clk); #1;
        log_en = 1;
        s_m0_req = 1; s_m0_addr = 8'h30; s_m1_req = 1; s_m1_addr = 8'h40;
        repeat (12) @(posedge clk);
        #1 s_m0_req = 0; s_m1_req = 0;
        repeat (3) @(posedge clk);
        #1 log_en = 0;
        check("rr_grant_count", 32'(g_who.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < g_who.size()) begin
                check($sformatf("rr_owner_%0d", i), 32'(g_who[i]), 32'(i % 2));
                if (i > 0) check($sformatf("rr_spacing_%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 3);
            end
        end
        check("fp_m1_grants", 32'(fp_m1), 0);
        check("fp_m0_grants", 32'(fp_m0), 4);

        // m1 arrives during m0's ACCESS
        @(posedge clk); #1;
        s_m0_req = 1; s_m0_write = 0; s_m0_addr = 8'h50;
        @(posedge clk); #1;
        s_m0_req = 0; s_m1_req = 1; s_m1_write = 0; s_m1_addr = 8'h60;
        @(negedge clk);
        check("late_m0_gnt", 32'(bus0.m0_gnt), 1);
        check("late_m1_gnt_access", 32'(bus0.m1_gnt), 0);
        @(negedge clk);
        check("late_m0_rvalid", 32'(bus0.m0_rvalid), 1);
        check("late_m1_gnt_resp", 32'(bus0.m1_gnt), 0);
        @(negedge clk);
        check("late_m1_gnt_idle", 32'(bus0.m1_gnt), 0);
        @(negedge clk);
        check("late_m1_gnt", 32'(bus0.m1_gnt), 1);
        @(posedge clk); #1 s_m1_req = 0;
        repeat (3) @(negedge clk);

        // reset during RESP of an m0 read of 0x10
        @(posedge clk); #1;
        s_m0_req = 1; s_m0_write = 0; s_m0_addr = 8'h10;
        @(posedge clk); @(negedge clk);
        check("abort_m0_gnt", 32'(bus0.m0_gnt), 1);
        @(posedge clk); #1;
        check("abort_rvalid_before", 32'(bus0.m0_rvalid), 1);
        check("abort_rdata_before", 32'(bus0.m0_rdata), 'hA5);
        #1 reset = 1'b0;
        #1;
        check("abort_rvalid_after", 32'(bus0.m0_rvalid), 0);
        check("abort_rdata_after", 32'(bus0.m0_rdata), 0);
        check("abort_busy", 32'(bus0.busy), 0);
        check("abort_address", 32'(bus0.address), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("regrant_m0_gnt", 32'(bus0.m0_gnt), 1);
        check("regrant_address", 32'(bus0.address), 'h10);
        @(posedge clk); #1 s_m0_req = 0;
        @(negedge clk);
        check("regrant_rvalid", 32'(bus0.m0_rvalid), 1);
        check("regrant_rdata", 32'(bus0.m0_rdata), 'hA5);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
